// File: rtl/ab_seq_pkg.sv
// Shared types, defaults and helpers for the a/b handshake sequence generator.
package ab_seq_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} ab_state_e;

   localparam int A_LEN_DEF   = 2;
   localparam int B_DELAY_DEF = 1;
   localparam int B_LEN_DEF   = 2;
   localparam int CNT_W_DEF   = 8;

   function automatic int ab_max(int x, int y);
      return (x > y) ? x : y;
   endfunction

endpackage

// File: rtl/ab_seq_gen_rise_det.sv
// Rising-edge detector: registers d and flags cycles where d is high but was low.
module rise_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) d_q <= 1'b0;
      else        d_q <= d;
   end

   assign rise = d & ~d_q;

endmodule

// File: rtl/ab_seq_gen.sv
// Stimulus generator for the a/b/done handshake with busy, drop and completion count.
// Optional concurrent assertions are compiled when AB_SEQ_GEN_ASSERT_EN is defined.
module ab_seq_gen
   import ab_seq_pkg::*;
#(
   parameter int A_LEN   = A_LEN_DEF,
   parameter int B_DELAY = B_DELAY_DEF,
   parameter int B_LEN   = B_LEN_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a,
   output logic             b,
   output logic             done,
   output logic             busy,
   output logic             drop,
   output logic [CNT_W-1:0] txn_cnt
);

   localparam int L  = ab_max(A_LEN, B_DELAY + B_LEN);
   localparam int CW = $clog2(L + 1);

   generate
      if (A_LEN < 1) begin : g_bad_a_len
         $error("ab_seq_gen: A_LEN must be >= 1");
      end
      if (B_DELAY < 0) begin : g_bad_b_delay
         $error("ab_seq_gen: B_DELAY must be >= 0");
      end
      if (B_LEN < 1) begin : g_bad_b_len
         $error("ab_seq_gen: B_LEN must be >= 1");
      end
   endgenerate

   logic rise;

   rise_det u_rise_det (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (start),
      .rise (rise)
   );

   ab_state_e        state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             a_reg, a_next, b_reg, b_next, done_reg, done_next;
   logic             busy_reg, busy_next, drop_reg, drop_next;
   logic [CNT_W-1:0] txn_reg, txn_next;
   int               k;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= 1'b0;
         b_reg     <= 1'b0;
         done_reg  <= 1'b0;
         busy_reg  <= 1'b0;
         drop_reg  <= 1'b0;
         txn_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         done_reg  <= done_next;
         busy_reg  <= busy_next;
         drop_reg  <= drop_next;
         txn_reg   <= txn_next;
      end
   end

   // Outputs are computed one cycle ahead: k is the RUN cycle index the new values belong to.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      a_next     = 1'b0;
      b_next     = 1'b0;
      done_next  = 1'b0;
      busy_next  = 1'b0;
      drop_next  = 1'b0;
      txn_next   = txn_reg;
      k          = int'(cnt_reg) + 1;
      case (state_reg)
         RUN: begin
            drop_next = rise;
            if (k == L) begin
               state_next = DONE;
               done_next  = 1'b1;
            end else begin
               cnt_next  = CW'(k);
               a_next    = (k < A_LEN);
               b_next    = (k >= B_DELAY) && (k < B_DELAY + B_LEN);
               busy_next = 1'b1;
            end
         end
         DONE: begin
            txn_next   = txn_reg + CNT_W'(1);
            state_next = IDLE;
            if (rise) begin
               state_next = RUN;
               cnt_next   = '0;
               a_next     = 1'b1;
               b_next     = (B_DELAY == 0);
               busy_next  = 1'b1;
            end
         end
         default: begin
            if (rise) begin
               state_next = RUN;
               cnt_next   = '0;
               a_next     = 1'b1;
               b_next     = (B_DELAY == 0);
               busy_next  = 1'b1;
            end
         end
      endcase
   end

   assign a       = a_reg;
   assign b       = b_reg;
   assign done    = done_reg;
   assign busy    = busy_reg;
   assign drop    = drop_reg;
   assign txn_cnt = txn_reg;

`ifdef AB_SEQ_GEN_ASSERT_EN
   logic accepted;
   assign accepted = rise && (state_reg != RUN);

   a_seq_chk: assert property (@(posedge clk) disable iff (!rst_n) accepted |=> a [*A_LEN])
      else $error("ab_seq_gen: a sequence violated at %0t", $time);
   b_seq_chk: assert property (@(posedge clk) disable iff (!rst_n) accepted |=> ##B_DELAY b [*B_LEN])
      else $error("ab_seq_gen: b sequence violated at %0t", $time);
   done_chk: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done)
      else $error("ab_seq_gen: done longer than one cycle at %0t", $time);
   drop_chk: assert property (@(posedge clk) disable iff (!rst_n) drop |-> $past(busy))
      else $error("ab_seq_gen: drop without busy at %0t", $time);
`endif

endmodule

// File: tb/tb_ab_seq_gen.sv
// Bench for ab_seq_gen: two configurations share one stimulus stream and an edge-window reference model.
module tb_ab_seq_gen;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] a_o, b_o, done_o, busy_o, drop_o;
   logic [7:0] txn0;
   logic [1:0] txn1;

   ab_seq_gen dut0 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a_o[0]), .b(b_o[0]), .done(done_o[0]), .busy(busy_o[0]), .drop(drop_o[0]),
      .txn_cnt(txn0)
   );

   ab_seq_gen #(.A_LEN(3), .B_DELAY(0), .B_LEN(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a_o[1]), .b(b_o[1]), .done(done_o[1]), .busy(busy_o[1]), .drop(drop_o[1]),
      .txn_cnt(txn1)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int alen[2] = '{2, 3};
   int bdel[2] = '{1, 0};
   int blen[2] = '{2, 1};
   int cw[2]   = '{8, 2};
   int last_t[2];
   int ign_t[2];
   int n_acc[2];
   bit prev_start;

   function automatic int seq_len(int k);
      return (alen[k] > bdel[k] + blen[k]) ? alen[k] : bdel[k] + blen[k];
   endfunction

   task automatic model_reset();
      prev_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         last_t[k] = -1000;
         ign_t[k]  = -1000;
         n_acc[k]  = 0;
      end
   endtask

   // A rise at edge n is accepted unless the previous sequence still occupies edges last_t+1..last_t+L.
   task automatic model_edge(input int n);
      bit r;
      if (!rst_n) begin
         prev_start = 1'b0;
      end else begin
         r = start && !prev_start;
         prev_start = start;
         if (r) begin
            for (int k = 0; k < 2; k++) begin
               if (n > last_t[k] + seq_len(k)) begin
                  last_t[k] = n;
                  n_acc[k]++;
               end else begin
                  ign_t[k] = n;
               end
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare every output against the values expected to be sampled at edge m.
   task automatic check_all(input int m);
      int t, l, pend;
      logic [31:0] e_txn, o_txn;
      for (int k = 0; k < 2; k++) begin
         t = last_t[k];
         l = seq_len(k);
         pend = (m < t + l + 2) ? 1 : 0;
         e_txn = 32'((n_acc[k] - pend) % (1 << cw[k]));
         o_txn = (k == 0) ? 32'(txn0) : 32'(txn1);
         check($sformatf("a%0d@%0d", k, m),    32'(a_o[k]),    32'(m >= t + 1 && m <= t + alen[k]));
         check($sformatf("b%0d@%0d", k, m),    32'(b_o[k]),    32'(m >= t + 1 + bdel[k] && m <= t + bdel[k] + blen[k]));
         check($sformatf("done%0d@%0d", k, m), 32'(done_o[k]), 32'(m == t + l + 1));
         check($sformatf("busy%0d@%0d", k, m), 32'(busy_o[k]), 32'(m >= t + 1 && m <= t + l));
         check($sformatf("drop%0d@%0d", k, m), 32'(drop_o[k]), 32'(ign_t[k] == m - 1));
         check($sformatf("txn%0d@%0d", k, m),  o_txn,          e_txn);
      end
   endtask

   task automatic step(input bit s);
      start = s;
      @(posedge clk);
      edge_n++;
      model_edge(edge_n);
      #1;
      check_all(edge_n + 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0);
   endtask

   initial begin
      model_reset();
      #2;
      check_all(edge_n + 1);
      step(1'b0);
      step(1'b0);
      #3 rst_n = 1'b1;

      // single pulse
      step(1'b1); idle(6);
      // second rise while busy is dropped
      step(1'b1); step(1'b0); step(1'b1); idle(6);
      // back-to-back: second rise lands on the DONE edge
      step(1'b1); idle(3); step(1'b1); idle(8);
      // level held high yields a single sequence
      for (int i = 0; i < 10; i++) step(1'b1);
      idle(5);

      // reset mid-run with start held high through release
      step(1'b1); step(1'b0);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_all(edge_n + 1);
      step(1'b1); step(1'b1);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) step(1'b1);
      idle(3);

      // randomized start traffic; covers drops, back-to-back and counter wrap
      for (int i = 0; i < 400; i++) step($urandom_range(0, 3) == 0);
      idle(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
